// File: rtl/udp_app_pkg.sv
`default_nettype none
// ============================================================================
// Module      : udp_app_pkg
// Description : Shared definitions for the UDP application-layer receive
//               deframer. Contains the header magic value, the bit offsets of
//               the header fields in word 0, the header size, the deframer
//               state encoding and the keep-mask helper.
// Revision    : 1.0 - initial release
// ============================================================================
package udp_app_pkg;

    // Default magic value expected in header bits [15:0]
    localparam logic [15:0] HDR_MAGIC      = 16'hA55A;

    // Header occupies exactly one 64-bit word
    localparam int          HDR_BYTES      = 8;

    // Bit offsets of the header fields inside word 0
    localparam int          HDR_MAGIC_LSB  = 0;
    localparam int          HDR_SEQ_LSB    = 16;
    localparam int          HDR_LEN_LSB    = 32;
    localparam int          HDR_TYPE_LSB   = 48;
    localparam int          HDR_FLAGS_LSB  = 56;

    // Deframer state encoding
    localparam logic [1:0]  S_HDR          = 2'd0;
    localparam logic [1:0]  S_PAYLOAD      = 2'd1;
    localparam logic [1:0]  S_DROP         = 2'd2;

    // LSB-contiguous byte-keep mask for a word given the payload bytes still
    // owed by the frame. Eight or more remaining bytes give a full word.
    function automatic logic [7:0] keep_from_remaining(input logic [15:0] rem);
        logic [7:0] keep;
        if (rem >= 16'(HDR_BYTES)) begin
            keep = 8'hFF;
        end else begin
            keep = (8'd1 << rem[2:0]) - 8'd1;
        end
        return keep;
    endfunction

endpackage : udp_app_pkg
`default_nettype wire

// File: rtl/udp_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : udp_sat_counter
// Description : Saturating event counter with synchronous clear.
//               clr has priority over inc; the count sticks at all-ones.
// Ports       : clk      - clock
//               rst_n    - asynchronous active-low reset
//               i_clr    - synchronous clear
//               i_inc    - increment request
//               o_count  - current count
// Revision    : 1.0 - initial release
// ============================================================================
module udp_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule : udp_sat_counter
`default_nettype wire

// File: rtl/udp_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module      : udp_rx_deframer
// Description : Application-layer deframer on the UDP receive path. Word 0 of
//               each datagram carries an 8-byte header (magic, sequence,
//               length, type, flags). The header is validated and stripped;
//               payload words are forwarded through a single output register
//               with a byte-keep mask, a frame-error flag on the last beat and
//               per-frame header sideband. Four saturating status counters
//               are exposed to firmware.
// Ports       : sys_clk, sys_rst_n          - clock, async active-low reset
//               s_data/s_valid/s_last/s_ready - input payload words
//               m_data/m_keep/m_valid/m_last/m_err/m_ready - output beats
//               m_type/m_seq/m_len/m_seq_gap  - per-frame header sideband
//               clr_cnt                       - synchronous counter clear
//               cnt_frame_ok/cnt_frame_err/cnt_bad_hdr/cnt_seq_gap - counters
// Revision    : 1.0 - initial release
// ============================================================================
module udp_rx_deframer
    import udp_app_pkg::*;
#(
    parameter int          DATA_W  = 64,
    parameter logic [15:0] MAGIC   = HDR_MAGIC,
    parameter int          MAX_LEN = 8184,
    parameter int          CNT_W   = 32
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,

    input  logic [DATA_W-1:0]   s_data,
    input  logic                s_valid,
    input  logic                s_last,
    output logic                s_ready,

    output logic [DATA_W-1:0]   m_data,
    output logic [DATA_W/8-1:0] m_keep,
    output logic                m_valid,
    output logic                m_last,
    output logic                m_err,
    input  logic                m_ready,

    output logic [7:0]          m_type,
    output logic [15:0]         m_seq,
    output logic [15:0]         m_len,
    output logic                m_seq_gap,

    input  logic                clr_cnt,
    output logic [CNT_W-1:0]    cnt_frame_ok,
    output logic [CNT_W-1:0]    cnt_frame_err,
    output logic [CNT_W-1:0]    cnt_bad_hdr,
    output logic [CNT_W-1:0]    cnt_seq_gap
);

    localparam logic [15:0] c_max_len = 16'(MAX_LEN);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [15:0]         r_remaining;
    logic                r_seq_valid;
    logic [15:0]         r_exp_seq;

    // Header of the frame currently being parsed; copied to the sideband
    // outputs only when a payload beat is loaded, so a pending last beat of
    // the previous frame keeps its own sideband while the next header arrives.
    logic [7:0]          r_hdr_type;
    logic [15:0]         r_hdr_seq;
    logic [15:0]         r_hdr_len;
    logic                r_hdr_gap;

    // Output register
    logic [DATA_W-1:0]   r_m_data;
    logic [DATA_W/8-1:0] r_m_keep;
    logic                r_m_valid;
    logic                r_m_last;
    logic                r_m_err;
    logic [7:0]          r_m_type;
    logic [15:0]         r_m_seq;
    logic [15:0]         r_m_len;
    logic                r_m_seq_gap;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [15:0] w_magic;
    logic [15:0] w_seq;
    logic [15:0] w_len;
    logic [7:0]  w_type;
    logic        w_accept;
    logic        w_hdr_bad;
    logic        w_gap;
    logic        w_load;
    logic [15:0] w_rem_next;
    logic        w_rem_zero;

    logic [1:0]  w_state_nxt;
    logic        w_last_nxt;
    logic        w_err_nxt;
    logic        w_inc_ok;
    logic        w_inc_err;
    logic        w_inc_bad;
    logic        w_inc_gap;

    assign w_magic    = s_data[HDR_MAGIC_LSB +: 16];
    assign w_seq      = s_data[HDR_SEQ_LSB   +: 16];
    assign w_len      = s_data[HDR_LEN_LSB   +: 16];
    assign w_type     = s_data[HDR_TYPE_LSB  +: 8];

    // Only the payload state is throttled by the output register
    assign s_ready    = (r_state == S_PAYLOAD) ? (!r_m_valid || m_ready) : 1'b1;
    assign w_accept   = s_valid && s_ready;
    assign w_load     = w_accept && (r_state == S_PAYLOAD);

    assign w_hdr_bad  = (w_magic != MAGIC) || (w_len > c_max_len);
    assign w_gap      = r_seq_valid && (w_seq != r_exp_seq);

    assign w_rem_next = (r_remaining >= 16'(HDR_BYTES)) ? (r_remaining - 16'(HDR_BYTES)) : 16'd0;
    assign w_rem_zero = (w_rem_next == 16'd0);

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_inc_ok    = 1'b0;
        w_inc_err   = 1'b0;
        w_inc_bad   = 1'b0;
        w_inc_gap   = 1'b0;

        if (w_accept) begin
            case (r_state)
                S_HDR: begin
                    if (w_hdr_bad) begin
                        w_inc_bad   = 1'b1;
                        w_state_nxt = s_last ? S_HDR : S_DROP;
                    end else begin
                        w_inc_gap = w_gap;
                        if (w_len == 16'd0) begin
                            // Empty frame is only correct as a header-only datagram
                            if (s_last) begin
                                w_inc_ok = 1'b1;
                            end else begin
                                w_inc_err   = 1'b1;
                                w_state_nxt = S_DROP;
                            end
                        end else if (s_last) begin
                            w_inc_err = 1'b1;
                        end else begin
                            w_state_nxt = S_PAYLOAD;
                        end
                    end
                end

                S_PAYLOAD: begin
                    if (s_last) begin
                        // Exact end or short frame
                        w_last_nxt  = 1'b1;
                        w_err_nxt   = !w_rem_zero;
                        w_inc_ok    = w_rem_zero;
                        w_inc_err   = !w_rem_zero;
                        w_state_nxt = S_HDR;
                    end else if (w_rem_zero) begin
                        // Long frame: close it now, discard the excess words
                        w_last_nxt  = 1'b1;
                        w_err_nxt   = 1'b1;
                        w_inc_err   = 1'b1;
                        w_state_nxt = S_DROP;
                    end
                end

                S_DROP: begin
                    if (s_last) begin
                        w_state_nxt = S_HDR;
                    end
                end

                default: begin
                    w_state_nxt = S_HDR;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= S_HDR;
            r_remaining <= 16'd0;
            r_seq_valid <= 1'b0;
            r_exp_seq   <= 16'd0;
            r_hdr_type  <= 8'd0;
            r_hdr_seq   <= 16'd0;
            r_hdr_len   <= 16'd0;
            r_hdr_gap   <= 1'b0;
            r_m_data    <= '0;
            r_m_keep    <= '0;
            r_m_valid   <= 1'b0;
            r_m_last    <= 1'b0;
            r_m_err     <= 1'b0;
            r_m_type    <= 8'd0;
            r_m_seq     <= 16'd0;
            r_m_len     <= 16'd0;
            r_m_seq_gap <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_accept && (r_state == S_HDR) && !w_hdr_bad) begin
                r_hdr_type  <= w_type;
                r_hdr_seq   <= w_seq;
                r_hdr_len   <= w_len;
                r_hdr_gap   <= w_gap;
                r_remaining <= w_len;
                r_exp_seq   <= w_seq + 16'd1;
                r_seq_valid <= 1'b1;
            end else if (w_load) begin
                r_remaining <= w_rem_next;
            end

            if (w_load) begin
                r_m_valid   <= 1'b1;
                r_m_data    <= s_data;
                r_m_keep    <= keep_from_remaining(r_remaining);
                r_m_last    <= w_last_nxt;
                r_m_err     <= w_err_nxt;
                r_m_type    <= r_hdr_type;
                r_m_seq     <= r_hdr_seq;
                r_m_len     <= r_hdr_len;
                r_m_seq_gap <= r_hdr_gap;
            end else if (m_ready) begin
                r_m_valid   <= 1'b0;
            end
        end
    end

    assign m_data    = r_m_data;
    assign m_keep    = r_m_keep;
    assign m_valid   = r_m_valid;
    assign m_last    = r_m_last;
    assign m_err     = r_m_err;
    assign m_type    = r_m_type;
    assign m_seq     = r_m_seq;
    assign m_len     = r_m_len;
    assign m_seq_gap = r_m_seq_gap;

    // ------------------------------------------------------------------
    // Status counters
    // ------------------------------------------------------------------
    udp_sat_counter #(.WIDTH(CNT_W)) u_cnt_frame_ok (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .i_clr   (clr_cnt),
        .i_inc   (w_inc_ok),
        .o_count (cnt_frame_ok)
    );

    udp_sat_counter #(.WIDTH(CNT_W)) u_cnt_frame_err (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .i_clr   (clr_cnt),
        .i_inc   (w_inc_err),
        .o_count (cnt_frame_err)
    );

    udp_sat_counter #(.WIDTH(CNT_W)) u_cnt_bad_hdr (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .i_clr   (clr_cnt),
        .i_inc   (w_inc_bad),
        .o_count (cnt_bad_hdr)
    );

    udp_sat_counter #(.WIDTH(CNT_W)) u_cnt_seq_gap (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .i_clr   (clr_cnt),
        .i_inc   (w_inc_gap),
        .o_count (cnt_seq_gap)
    );

endmodule : udp_rx_deframer
`default_nettype wire

// File: doc/udp_rx_deframer.md
Name: udp_rx_deframer

Overview:
- Downstream stage of the UDP receive path, in the sys_clk domain.
- Consumes packed 64-bit payload words (`dout_data/valid/last/ready`).
- Parses the 8-byte application header in word 0 and validates magic, length and sequence.
- Strips the header and emits payload words with byte-keep, frame error flag and header sideband, plus saturating status counters for firmware.

Parameters:
- DATA_W, 64, word width; header layout requires 64 (other values unsupported).
- MAGIC, 16'hA55A, required value of header bits [15:0].
- MAX_LEN, 8184, largest legal payload length in bytes; above this is a bad header.
- CNT_W, 32, width of each status counter.

Ports:
- sys_clk  in  1  sole clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- s_data  in  DATA_W  payload word; byte k in bits [8k+7:8k]; last word zero-padded.
- s_valid  in  1  word valid.
- s_last  in  1  last word of UDP datagram.
- s_ready  out  1  word accepted when s_valid&&s_ready.
- m_data  out  DATA_W  payload word, same byte order.
- m_keep  out  DATA_W/8  valid-byte mask, LSB-contiguous.
- m_valid  out  1  output word valid.
- m_last  out  1  last payload word of frame.
- m_err  out  1  frame error (length mismatch); meaningful only with m_last.
- m_ready  in  1  downstream accept.
- m_type  out  8  header type byte, constant for the whole frame.
- m_seq  out  16  header sequence number, constant for the whole frame.
- m_len  out  16  header payload length, constant for the whole frame.
- m_seq_gap  out  1  frame seq differed from expected; constant for the whole frame.
- clr_cnt  in  1  synchronous clear of all counters.
- cnt_frame_ok  out  CNT_W  frames ending without error.
- cnt_frame_err  out  CNT_W  frames with length error.
- cnt_bad_hdr  out  CNT_W  frames dropped for bad magic or length > MAX_LEN.
- cnt_seq_gap  out  CNT_W  sequence discontinuities.

Behaviour:
- Reset: state HDR; m_valid=0, m_last=0, m_err=0, m_keep=0, m_data=0; sideband=0; counters=0; seq_valid=0.
- Header fields: magic=[15:0], seq=[31:16], len=[47:32], type=[55:48], flags [63:56] ignored.
- Output register, single stage: s_ready = !m_valid || m_ready in PAYLOAD. s_ready=1 in HDR and DROP, which produce no output. Latency is one cycle from input word to m_valid.
- m_* hold stable while m_valid && !m_ready.
- HDR, on accept:
  - Bad magic or len>MAX_LEN: cnt_bad_hdr++; go to DROP if !s_last, else stay in HDR.
  - Otherwise latch type/seq/len and set remaining=len.
  - Sequence check: if seq_valid && seq!=exp_seq, then m_seq_gap=1 and cnt_seq_gap++. Then exp_seq=seq+1 (mod 2^16) and seq_valid=1.
  - Good header, len=0: if s_last, cnt_frame_ok++ and stay in HDR with no output; else cnt_frame_err++ and go to DROP.
  - Good header, len>0: if s_last, cnt_frame_err++ and stay in HDR with no output; else go to PAYLOAD.
- PAYLOAD, on accept:
  - m_data=s_data; m_keep = remaining>=8 ? 8'hFF : (1<<remaining)-1; remaining -= min(remaining,8).
  - Exact end (remaining reaches 0 and s_last): m_last=1, m_err=0, cnt_frame_ok++, go to HDR.
  - Short (s_last while remaining stays >0): m_last=1, m_err=1, cnt_frame_err++, go to HDR.
  - Long (remaining reaches 0 and !s_last): m_last=1, m_err=1, cnt_frame_err++, go to DROP.
- DROP: accept and discard words; on s_last go to HDR.
- Counters saturate at all-ones. clr_cnt has priority over an increment in the same cycle. Increments from one event occur in the same cycle, so bad-header and seq counting never coincide.
- Reset mid-frame aborts any pending output word (m_valid drops immediately). The upstream path shares the reset, so the next word after reset is a header.

Decomposition:
- Package udp_app_pkg holds:
  - HDR_MAGIC, field bit offsets, header byte count 8;
  - state encoding (HDR, PAYLOAD, DROP);
  - the keep-from-remaining function.
- One natural sub-module: udp_sat_counter, the saturating counter with clear, instantiated four times.

Test Plan:
- Header A55A/seq 5/len 20/type 3, then 3 words → 3 outputs; keeps FF,FF,0F; m_last on the third; m_err=0; cnt_frame_ok=1.
- Next frame seq 9 (expected 6) → m_seq_gap=1 on all beats; cnt_seq_gap=1; then seq 10 → no gap.
- Magic 0x1234, 4-word frame → no m_valid; s_ready=1 throughout; cnt_bad_hdr=1; next good frame parses normally.
- len=24 but s_last on the 2nd payload word → 2 beats, second has m_last=1, m_err=1, keep FF; cnt_frame_err=1.
- len=8 followed by 3 payload words → 1 beat, m_last=1, m_err=1; 2 words dropped; cnt_frame_err++.
- m_ready held low 10 cycles mid-frame → m_data/m_keep stable, s_ready=0, no loss. Assert sys_rst_n low mid-frame → all outputs and counters 0 asynchronously.
